// File: rtl/wb_queue_pkg.sv
// wb_queue_pkg: shared types and constants for the writeback queue.
//   wb_entry_t : one queued register-file write {dst, data}
//   REG_ZERO   : architectural zero register; writes to it are dropped
package wb_queue_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [4:0]  dst;
    logic [31:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// wb_fwd_match: finds the youngest queued write to a decode read address.
//   entries_i : queue storage (indexed by pointer)
//   tail_i    : next free slot; youngest valid entry sits at tail_i-1
//   count_i   : number of valid entries
//   addr_i    : decode-stage read address
//   hit_o     : a valid entry targets addr_i (never for the zero register)
//   data_o    : data of the youngest matching entry, else 0
module wb_fwd_match
  import wb_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int CNT_W = 3
) (
  input  wb_entry_t          entries_i [DEPTH],
  input  logic [PTR_W-1:0]   tail_i,
  input  logic [CNT_W-1:0]   count_i,
  input  logic [4:0]         addr_i,
  output logic               hit_o,
  output logic [31:0]        data_o
);

  logic             found;
  logic [31:0]      found_data;
  logic [PTR_W-1:0] idx;

  // Walk from the youngest entry (tail-1) back towards head; the first
  // match wins, so a later write to the same register shadows older ones.
  always_comb begin
    found      = 1'b0;
    found_data = '0;
    idx        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = tail_i - PTR_W'(i + 1);
      if (!found && (CNT_W'(i) < count_i) && (addr_i != REG_ZERO) &&
          (entries_i[idx].dst == addr_i)) begin
        found      = 1'b1;
        found_data = entries_i[idx].data;
      end
    end
  end

  assign hit_o  = found;
  assign data_o = found_data;

endmodule

// File: rtl/wb_queue.sv
// wb_queue: writeback queue merging ALU and load results into one
// register-file write port, with forwarding of pending writes to decode.
//   clk, reset                 : clock, synchronous active-high reset
//   alu_valid/alu_ready        : ALU producer handshake (alu_dst, alu_data)
//   mem_valid/mem_ready        : load producer handshake (mem_dst, mem_data)
//   wr_en, wr_addr, wr_data    : register-file write of the head entry
//   flush                      : drop every queued write at the edge
//   fwd_addr_a/b               : decode read addresses
//   fwd_hit_a/b, fwd_data_a/b  : youngest pending write to those addresses
// Handshake: a producer transfers on a rising edge where valid && ready.
// Ready depends only on registered occupancy (plus alu_valid for the load
// port), never on valid of the same port or on a same-cycle pop.
module wb_queue
  import wb_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_dst,
  input  logic [31:0] alu_data,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_dst,
  input  logic [31:0] mem_data,
  output logic        wr_en,
  output logic [4:0]  wr_addr,
  output logic [31:0] wr_data,
  input  logic        flush,
  input  logic [4:0]  fwd_addr_a,
  input  logic [4:0]  fwd_addr_b,
  output logic        fwd_hit_a,
  output logic        fwd_hit_b,
  output logic [31:0] fwd_data_a,
  output logic [31:0] fwd_data_b
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t          entries_q [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   free;
  logic [PTR_W-1:0]   mem_idx;
  logic               alu_push, mem_push, pop;

  assign free = CNT_W'(DEPTH) - count_q;

  // The load port needs two free slots when the ALU is also offering,
  // because the ALU entry is always enqueued first.
  assign alu_ready = !reset && !flush && (free >= CNT_W'(1));
  assign mem_ready = !reset && !flush &&
                     (alu_valid ? (free >= CNT_W'(2)) : (free >= CNT_W'(1)));

  // Zero-register writes complete the handshake but are never stored.
  assign alu_push = alu_valid && alu_ready && (alu_dst != REG_ZERO);
  assign mem_push = mem_valid && mem_ready && (mem_dst != REG_ZERO);
  assign pop      = (count_q != '0);
  assign mem_idx  = tail_q + PTR_W'(alu_push);

  always_comb begin
    head_d  = head_q + PTR_W'(pop);
    tail_d  = tail_q + PTR_W'(alu_push) + PTR_W'(mem_push);
    count_d = count_q + CNT_W'(alu_push) + CNT_W'(mem_push) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is left uncleared; pushes are already blocked under reset/flush.
  always_ff @(posedge clk) begin
    if (alu_push) entries_q[tail_q]  <= '{dst: alu_dst, data: alu_data};
    if (mem_push) entries_q[mem_idx] <= '{dst: mem_dst, data: mem_data};
  end

  assign wr_en   = pop;
  assign wr_addr = pop ? entries_q[head_q].dst  : '0;
  assign wr_data = pop ? entries_q[head_q].data : '0;

  wb_fwd_match #(.DEPTH(DEPTH), .PTR_W(PTR_W), .CNT_W(CNT_W)) u_fwd_a (
    .entries_i (entries_q),
    .tail_i    (tail_q),
    .count_i   (count_q),
    .addr_i    (fwd_addr_a),
    .hit_o     (fwd_hit_a),
    .data_o    (fwd_data_a)
  );

  wb_fwd_match #(.DEPTH(DEPTH), .PTR_W(PTR_W), .CNT_W(CNT_W)) u_fwd_b (
    .entries_i (entries_q),
    .tail_i    (tail_q),
    .count_i   (count_q),
    .addr_i    (fwd_addr_b),
    .hit_o     (fwd_hit_b),
    .data_o    (fwd_data_b)
  );

endmodule

// File: tb/tb_wb_queue.sv
module tb_wb_queue;

  logic        clk;
  logic        reset;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_dst;
  logic [31:0] alu_data;
  logic        mem_valid, mem_ready;
  logic [4:0]  mem_dst;
  logic [31:0] mem_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        flush;
  logic [4:0]  fwd_addr_a, fwd_addr_b;
  logic        fwd_hit_a, fwd_hit_b;
  logic [31:0] fwd_data_a, fwd_data_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic [36:0] exp_q[$];

  wb_queue #(.DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_dst    (alu_dst),
    .alu_data   (alu_data),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_dst    (mem_dst),
    .mem_data   (mem_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .flush      (flush),
    .fwd_addr_a (fwd_addr_a),
    .fwd_addr_b (fwd_addr_b),
    .fwd_hit_a  (fwd_hit_a),
    .fwd_hit_b  (fwd_hit_b),
    .fwd_data_a (fwd_data_a),
    .fwd_data_b (fwd_data_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // inputs change 1ns after the active edge, outputs sampled before the next
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_dst = '0; alu_data = '0;
    mem_valid = 1'b0; mem_dst = '0; mem_data = '0;
    flush = 1'b0;
  endtask

  task automatic drive_alu(input logic v, input logic [4:0] d, input logic [31:0] x);
    alu_valid = v; alu_dst = d; alu_data = x;
  endtask

  task automatic drive_mem(input logic v, input logic [4:0] d, input logic [31:0] x);
    mem_valid = v; mem_dst = d; mem_data = x;
  endtask

  // scoreboard step for the backpressure run: checks readies from model
  // occupancy, checks the head write, then updates the expected queue
  task automatic sb_cycle();
    int   n;
    logic ea, em;
    n  = exp_q.size();
    ea = (n < 4);
    em = alu_valid ? (n <= 2) : (n <= 3);
    check("bp_alu_ready", alu_ready, ea);
    check("bp_mem_ready", mem_ready, em);
    check("bp_wr_en", wr_en, n != 0);
    if (n != 0) begin
      check("bp_wr_entry", {wr_addr, wr_data}, exp_q[0]);
      void'(exp_q.pop_front());
    end
    if (alu_valid && ea) exp_q.push_back({alu_dst, alu_data});
    if (mem_valid && em) exp_q.push_back({mem_dst, mem_data});
  endtask

  // leaves entries 11/A2, 12/A3, 13/A4 queued (head = 11), count 3
  task automatic fill_three();
    drive_alu(1'b1, 5'd10, 32'hA1);
    drive_mem(1'b1, 5'd11, 32'hA2);
    step();
    drive_alu(1'b1, 5'd12, 32'hA3);
    drive_mem(1'b1, 5'd13, 32'hA4);
    step();
    idle_inputs();
    #1;
  endtask

  initial begin
    idle_inputs();
    fwd_addr_a = 5'd7;
    fwd_addr_b = 5'd0;
    reset = 1'b1;
    drive_alu(1'b1, 5'd7, 32'h77);
    step();
    step();
    check("rst_alu_ready", alu_ready, 1'b0);
    check("rst_mem_ready", mem_ready, 1'b0);
    check("rst_wr_en", wr_en, 1'b0);
    check("rst_wr_addr", wr_addr, 5'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_hit_a", fwd_hit_a, 1'b0);
    reset = 1'b0;
    idle_inputs();
    #1;
    check("post_rst_wr_en", wr_en, 1'b0);
    check("post_rst_alu_ready", alu_ready, 1'b1);

    // single write
    drive_alu(1'b1, 5'd5, 32'hDEAD_BEEF);
    #1;
    check("single_alu_ready", alu_ready, 1'b1);
    step();
    idle_inputs();
    #1;
    check("single_wr_en", wr_en, 1'b1);
    check("single_wr_addr", wr_addr, 5'd5);
    check("single_wr_data", wr_data, 32'hDEAD_BEEF);
    step();
    check("single_empty", wr_en, 1'b0);

    // dual push to the same register: ALU is older
    drive_alu(1'b1, 5'd3, 32'd1);
    drive_mem(1'b1, 5'd3, 32'd2);
    #1;
    check("dual_mem_ready", mem_ready, 1'b1);
    step();
    idle_inputs();
    fwd_addr_a = 5'd3;
    #1;
    check("dual_first_addr", wr_addr, 5'd3);
    check("dual_first_data", wr_data, 32'd1);
    check("dual_fwd_hit_2q", fwd_hit_a, 1'b1);
    check("dual_fwd_data_2q", fwd_data_a, 32'd2);
    step();
    check("dual_second_en", wr_en, 1'b1);
    check("dual_second_data", wr_data, 32'd2);
    check("dual_fwd_data_1q", fwd_data_a, 32'd2);
    step();
    check("dual_empty", wr_en, 1'b0);
    check("dual_fwd_hit_0q", fwd_hit_a, 1'b0);

    // zero register
    drive_alu(1'b1, 5'd0, 32'd7);
    #1;
    check("zero_alu_ready", alu_ready, 1'b1);
    step();
    idle_inputs();
    #1;
    check("zero_no_write", wr_en, 1'b0);
    drive_alu(1'b1, 5'd0, 32'h55);
    drive_mem(1'b1, 5'd9, 32'h99);
    step();
    idle_inputs();
    fwd_addr_b = 5'd0;
    #1;
    check("zero_mix_addr", wr_addr, 5'd9);
    check("zero_mix_data", wr_data, 32'h99);
    check("zero_fwd_b_r0", fwd_hit_b, 1'b0);
    fwd_addr_b = 5'd9;
    #1;
    check("zero_fwd_b_hit", fwd_hit_b, 1'b1);
    check("zero_fwd_b_data", fwd_data_b, 32'h99);
    step();
    check("zero_single_pop", wr_en, 1'b0);

    // backpressure with continuous producers and a scoreboard
    for (int k = 0; k < 10; k++) begin
      drive_alu(k != 4, 5'(1 + k), 32'h100 + 32'(k));
      drive_mem((k % 3) != 2, 5'(16 + k), 32'h200 + 32'(k));
      #1;
      sb_cycle();
      step();
    end
    idle_inputs();
    for (int k = 0; k < 5; k++) begin
      #1;
      sb_cycle();
      step();
    end
    check("bp_drained", exp_q.size(), 0);

    // flush with three queued entries
    fill_three();
    fwd_addr_a = 5'd12;
    drive_alu(1'b1, 5'd20, 32'h20);
    drive_mem(1'b1, 5'd21, 32'h21);
    #1;
    check("c3_alu_ready", alu_ready, 1'b1);
    check("c3_mem_ready_blocked", mem_ready, 1'b0);
    alu_valid = 1'b0;
    #1;
    check("c3_mem_ready_alone", mem_ready, 1'b1);
    check("c3_fwd_data", fwd_data_a, 32'hA3);
    flush = 1'b1;
    alu_valid = 1'b1;
    #1;
    check("flush_alu_ready", alu_ready, 1'b0);
    check("flush_mem_ready", mem_ready, 1'b0);
    check("flush_head_en", wr_en, 1'b1);
    check("flush_head_addr", wr_addr, 5'd11);
    step();
    idle_inputs();
    #1;
    check("flush_after_en", wr_en, 1'b0);
    check("flush_after_hit", fwd_hit_a, 1'b0);

    // reset mid-operation
    fill_three();
    reset = 1'b1;
    drive_alu(1'b1, 5'd22, 32'h22);
    drive_mem(1'b1, 5'd23, 32'h23);
    #1;
    check("midrst_alu_ready", alu_ready, 1'b0);
    check("midrst_mem_ready", mem_ready, 1'b0);
    step();
    check("midrst_wr_en", wr_en, 1'b0);
    check("midrst_hit", fwd_hit_a, 1'b0);
    check("midrst_alu_ready2", alu_ready, 1'b0);
    reset = 1'b0;
    idle_inputs();
    step();
    check("midrst_after_en", wr_en, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
